serial_tx: RTL

- Parallel-in, serial-out frame transmitter. Sends one DATA_WIDTH-bit word as: start bit (0), data bits LSB first, stop bit (1).
- It is the transmit end of the serial link; the matching receiver deserialises into dff-based registers.
- Bit timing is paced by an external single-cycle beat strobe, so the block contains no baud divider.
- Sits between the debug/IO register bank and the serial pin.

---
 rtl/serial_pkg.sv | 32 +++
 rtl/dff.sv | 28 ++
 rtl/tx_bit_counter.sv | 50 +++++
 rtl/serial_tx.sv | 134 +++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// ============================================================================
// Module : serial_pkg
// Brief  : Types and helpers shared by the serial transmitter and receiver.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package serial_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        DATA  = 2'b10,
        STOP  = 2'b11
    } tx_state_t;

    function automatic logic start_bit_level(input logic idle_level);
        return ~idle_level;
    endfunction

    function automatic logic stop_bit_level(input logic idle_level);
        return idle_level;
    endfunction

    // Enough bits to hold the value DATA_WIDTH itself.
    function automatic int cnt_width(input int data_width);
        return $clog2(data_width + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/dff.sv
// ============================================================================
// Module : dff
// Brief  : Plain register with asynchronous active-low clear to RESET_VALUE.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module dff #(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            o_q <= RESET_VALUE;
        end else begin
            o_q <= i_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/tx_bit_counter.sv
// ============================================================================
// Module : tx_bit_counter
// Brief  : Data-bit counter: clear, increment on enable, terminal flag.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tx_bit_counter
    import serial_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic clk,
    input  logic clear_n,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_terminal
);

    localparam int                 c_cnt_w = cnt_width(DATA_WIDTH);
    localparam logic [c_cnt_w-1:0] c_term  = c_cnt_w'(DATA_WIDTH);

    logic [c_cnt_w-1:0] r_count;
    logic [c_cnt_w-1:0] w_count_d;

    // Saturates at the terminal value so the count can never wrap.
    always_comb begin
        w_count_d = r_count;
        if (i_clr) begin
            w_count_d = '0;
        end else if (i_inc && !o_terminal) begin
            w_count_d = r_count + c_cnt_w'(1);
        end
    end

    assign o_terminal = (r_count == c_term);

    dff #(
        .WIDTH       (c_cnt_w),
        .RESET_VALUE ('0)
    ) u_count (
        .clk     (clk),
        .clear_n (clear_n),
        .i_d     (w_count_d),
        .o_q     (r_count)
    );

endmodule

`default_nettype wire

// File: rtl/serial_tx.sv
// ============================================================================
// Module : serial_tx
// Brief  : Beat-paced serial frame transmitter (start, data LSB first, stop).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module serial_tx
    import serial_pkg::*;
#(
    parameter int   DATA_WIDTH = 8,
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  logic                  clk,
    input  logic                  clear_n,
    input  logic                  shift_en,
    input  logic [DATA_WIDTH-1:0] in,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  serial_out,
    output logic                  busy,
    output logic                  done
);

    localparam logic c_start_level = start_bit_level(IDLE_LEVEL);
    localparam logic c_stop_level  = stop_bit_level(IDLE_LEVEL);

    logic [1:0]            r_state_bits;
    tx_state_t             w_state;
    tx_state_t             w_state_d;
    logic [DATA_WIDTH-1:0] r_shreg;
    logic [DATA_WIDTH-1:0] w_shreg_d;
    logic                  r_line;
    logic                  w_line_d;
    logic                  r_done;
    logic                  w_done_d;
    logic                  w_cnt_clr;
    logic                  w_cnt_inc;
    logic                  w_cnt_term;
    logic                  w_accept;

    assign w_state  = tx_state_t'(r_state_bits);
    assign in_ready = (w_state == IDLE) | ((w_state == STOP) & shift_en);
    assign w_accept = in_valid & in_ready;

    always_comb begin
        w_state_d = w_state;
        w_shreg_d = r_shreg;
        w_line_d  = r_line;
        w_cnt_clr = 1'b0;
        w_cnt_inc = 1'b0;
        w_done_d  = 1'b0;
        case (w_state)
            IDLE: begin
                w_line_d = IDLE_LEVEL;
                if (w_accept) begin
                    w_shreg_d = in;
                    w_cnt_clr = 1'b1;
                    w_state_d = START;
                    w_line_d  = c_start_level;
                end
            end
            START: begin
                if (shift_en) begin
                    w_line_d  = r_shreg[0];
                    w_shreg_d = r_shreg >> 1;
                    w_cnt_inc = 1'b1;
                    w_state_d = DATA;
                end
            end
            DATA: begin
                if (shift_en) begin
                    if (!w_cnt_term) begin
                        w_line_d  = r_shreg[0];
                        w_shreg_d = r_shreg >> 1;
                        w_cnt_inc = 1'b1;
                    end else begin
                        w_line_d  = c_stop_level;
                        w_state_d = STOP;
                    end
                end
            end
            STOP: begin
                // A word accepted on the closing stop beat starts the next frame with no idle gap.
                if (shift_en) begin
                    w_done_d = 1'b1;
                    if (w_accept) begin
                        w_shreg_d = in;
                        w_cnt_clr = 1'b1;
                        w_state_d = START;
                        w_line_d  = c_start_level;
                    end else begin
                        w_state_d = IDLE;
                        w_line_d  = IDLE_LEVEL;
                    end
                end
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
    end

    dff #(.WIDTH(2), .RESET_VALUE(IDLE)) u_state (
        .clk (clk), .clear_n (clear_n), .i_d (w_state_d), .o_q (r_state_bits)
    );

    dff #(.WIDTH(DATA_WIDTH), .RESET_VALUE('0)) u_shreg (
        .clk (clk), .clear_n (clear_n), .i_d (w_shreg_d), .o_q (r_shreg)
    );

    dff #(.WIDTH(1), .RESET_VALUE(IDLE_LEVEL)) u_line (
        .clk (clk), .clear_n (clear_n), .i_d (w_line_d), .o_q (r_line)
    );

    dff #(.WIDTH(1), .RESET_VALUE(1'b0)) u_done (
        .clk (clk), .clear_n (clear_n), .i_d (w_done_d), .o_q (r_done)
    );

    tx_bit_counter #(.DATA_WIDTH(DATA_WIDTH)) u_bit_counter (
        .clk        (clk),
        .clear_n    (clear_n),
        .i_clr      (w_cnt_clr),
        .i_inc      (w_cnt_inc),
        .o_terminal (w_cnt_term)
    );

    assign serial_out = r_line;
    assign done       = r_done;
    assign busy       = (w_state != IDLE);

endmodule

`default_nettype wire
